// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: recovers duty (high cycles) and rise-to-rise period
// of an async PWM input; flags a stuck level when edges stop.
// Ports:
//   clk, rst_n   12MHz clock, async active-low reset
//   pwm_in       async PWM input
//   duty_out     last high time, saturated to PWM_INTERVAL-1
//   period_out   last rise-to-rise period, saturated to 2*TIMEOUT
//   valid        1-cycle pulse when outputs update
//   is_static    no edges for TIMEOUT cycles
module pwm_duty_capture #(
  parameter int PWM_INTERVAL = 1200,
  parameter int TIMEOUT      = 2*PWM_INTERVAL,
  localparam int DW = $clog2(PWM_INTERVAL),
  localparam int PW = $clog2(2*TIMEOUT+1),
  localparam int QW = $clog2(TIMEOUT+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_in,
  output logic [DW-1:0] duty_out,
  output logic [PW-1:0] period_out,
  output logic          valid,
  output logic          is_static
);

  typedef enum logic {IDLE, ARMED} state_e;

  localparam logic [PW-1:0] PER_MAX  = PW'(2*TIMEOUT);
  localparam logic [PW-1:0] HI_LIM   = PW'(PWM_INTERVAL-1);
  localparam logic [DW-1:0] DUTY_MAX = DW'(PWM_INTERVAL-1);
  localparam logic [QW-1:0] Q_MAX    = QW'(TIMEOUT);
  localparam logic [QW-1:0] Q_FIRE   = QW'(TIMEOUT-1);

  state_e        state_q;
  logic          s0_q, s1_q, prev_q;
  logic [PW-1:0] per_q, per_d;
  logic [PW-1:0] hi_q, hi_d;
  logic [QW-1:0] quiet_q, quiet_d;

  logic          rise, fall, edge_seen, fire;
  logic [DW-1:0] duty_sat;

  assign rise      = s1_q & ~prev_q;
  assign fall      = ~s1_q & prev_q;
  assign edge_seen = rise | fall;
  // an edge clears quiet_q, so fire and rise never coincide
  assign fire      = (quiet_q == Q_FIRE) & ~edge_seen;
  assign duty_sat  = (hi_q > HI_LIM) ? DUTY_MAX : hi_q[DW-1:0];

  always_comb begin
    per_d = per_q;
    if (rise)
      per_d = PW'(1);
    else if (per_q != PER_MAX)
      per_d = per_q + PW'(1);

    hi_d = hi_q;
    if (rise)
      hi_d = PW'(1);
    else if (s1_q && hi_q != PER_MAX)
      hi_d = hi_q + PW'(1);

    quiet_d = quiet_q;
    if (edge_seen)
      quiet_d = '0;
    else if (quiet_q != Q_MAX)
      quiet_d = quiet_q + QW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      prev_q     <= 1'b0;
      per_q      <= '0;
      hi_q       <= '0;
      quiet_q    <= '0;
      state_q    <= IDLE;
      duty_out   <= '0;
      period_out <= '0;
      valid      <= 1'b0;
      is_static  <= 1'b0;
    end else begin
      s0_q    <= pwm_in;
      s1_q    <= s0_q;
      prev_q  <= s1_q;
      per_q   <= per_d;
      hi_q    <= hi_d;
      quiet_q <= quiet_d;
      valid   <= 1'b0;
      unique case (1'b1)
        rise: begin
          if (state_q == ARMED) begin
            duty_out   <= duty_sat;
            period_out <= per_q;
            is_static  <= 1'b0;
            valid      <= 1'b1;
          end
          state_q <= ARMED;
        end
        fire: begin
          duty_out   <= s1_q ? DUTY_MAX : '0;
          period_out <= '0;
          is_static  <= 1'b1;
          valid      <= 1'b1;
          state_q    <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// tb_pwm_duty_capture: vector table, hand sequences and random
// stimulus against a sample-stream reference model.
module tb_pwm_duty_capture;

  localparam int PI = 1200;
  localparam int TO = 2*PI;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pwm_in = 1'b0;
  logic [10:0] duty_out;
  logic [12:0] period_out;
  logic        valid;
  logic        is_static;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_duty_capture #(
    .PWM_INTERVAL(PI),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwm_in(pwm_in),
    .duty_out(duty_out),
    .period_out(period_out),
    .valid(valid),
    .is_static(is_static)
  );

  // Reference model: works on the stream of samples of pwm_in taken
  // at each clock edge after reset release (sample 0 and earlier = 0).
  // A level change at sample m is reported at edge m+2; silence for
  // TO samples after the last change is reported the same way.
  typedef struct {
    int at;
    int duty;
    int per;
    bit st;
  } upd_t;

  upd_t pend[$];
  bit   ys[$];
  int   smp;
  int   last_rise;
  int   last_edge;
  bit   armed;
  int   e_duty, e_per;
  bit   e_st, e_valid;

  function automatic void model_reset();
    pend.delete();
    ys.delete();
    ys.push_back(1'b0);
    smp = 0;
    last_rise = -1;
    last_edge = -2;
    armed = 1'b0;
    e_duty = 0;
    e_per = 0;
    e_st = 1'b0;
    e_valid = 1'b0;
  endfunction

  function automatic void model_sample(bit v);
    int ones;
    int per;
    upd_t u;
    ys.push_back(v);
    if (v != ys[smp-1]) begin
      last_edge = smp;
      if (v) begin
        if (armed) begin
          ones = 0;
          for (int i = last_rise; i < smp; i++) ones += int'(ys[i]);
          per = smp - last_rise;
          u.at = smp + 2;
          u.duty = (ones > PI-1) ? PI-1 : ones;
          u.per = (per > 2*TO) ? 2*TO : per;
          u.st = 1'b0;
          pend.push_back(u);
        end
        armed = 1'b1;
        last_rise = smp;
      end
    end else if (smp == last_edge + TO) begin
      u.at = smp + 2;
      u.duty = v ? PI-1 : 0;
      u.per = 0;
      u.st = 1'b1;
      pend.push_back(u);
      armed = 1'b0;
    end
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // one clock: drive, sample edge, compare at the falling edge
  task automatic step(input bit v);
    pwm_in = v;
    @(posedge clk);
    smp++;
    model_sample(v);
    e_valid = 1'b0;
    while (pend.size() > 0 && pend[0].at == smp) begin
      e_duty = pend[0].duty;
      e_per = pend[0].per;
      e_st = pend[0].st;
      e_valid = 1'b1;
      void'(pend.pop_front());
    end
    @(negedge clk);
    checks++;
    if (valid !== e_valid || duty_out !== 11'(e_duty) ||
        period_out !== 13'(e_per) || is_static !== e_st) begin
      errors++;
      $display("FAIL model smp=%0d got v=%0b d=%0d p=%0d s=%0b want v=%0b d=%0d p=%0d s=%0b",
               smp, valid, duty_out, period_out, is_static,
               e_valid, e_duty, e_per, e_st);
    end
  endtask

  int g_nv, g_fsmp, g_fd, g_fp, g_fs, g_lsmp, g_ld, g_lp, g_ls;

  task automatic clr();
    g_nv = 0;
    g_fsmp = -1;
    g_lsmp = -1;
  endtask

  task automatic run(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      step(v);
      if (valid === 1'b1) begin
        if (g_nv == 0) begin
          g_fsmp = smp;
          g_fd = int'(duty_out);
          g_fp = int'(period_out);
          g_fs = int'(is_static);
        end
        g_lsmp = smp;
        g_ld = int'(duty_out);
        g_lp = int'(period_out);
        g_ls = int'(is_static);
        g_nv++;
      end
    end
  endtask

  task automatic do_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_duty", int'(duty_out), 0);
    chk("rst_per", int'(period_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_static", int'(is_static), 0);
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int hi;
    int per;
    int nper;
    int e_duty;
    int e_per;
  } vec_t;

  vec_t tbl[$];
  int   nv, rs, rs2, budget, m, h, l;

  initial begin
    tbl.push_back('{300, 1200, 4, 300, 1200});
    tbl.push_back('{2000, 2300, 2, 1199, 2300});
    tbl.push_back('{1, 3, 6, 1, 3});
    tbl.push_back('{1199, 1200, 3, 1199, 1200});
    tbl.push_back('{700, 1200, 3, 700, 1200});
    tbl.push_back('{2400, 4800, 2, 1199, 4800});

    // reset with pwm_in toggling, before any clock edge
    #1 rst_n = 1'b0;
    pwm_in = 1'b1;
    #1 pwm_in = 1'b0;
    chk("t0_duty", int'(duty_out), 0);
    chk("t0_per", int'(period_out), 0);
    chk("t0_valid", int'(valid), 0);
    chk("t0_static", int'(is_static), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    foreach (tbl[r]) begin
      do_reset(3);
      nv = 0;
      for (int p = 0; p < tbl[r].nper; p++) begin
        for (int c = 0; c < tbl[r].per; c++) begin
          if (c == 0) rs = smp + 1;
          step(c < tbl[r].hi);
          if (valid === 1'b1) begin
            nv++;
            checks++;
            if (int'(duty_out) != tbl[r].e_duty ||
                int'(period_out) != tbl[r].e_per ||
                is_static !== 1'b0 || smp - rs != 2) begin
              errors++;
              $display("FAIL tbl%0d got d=%0d p=%0d s=%0b lat=%0d want d=%0d p=%0d s=0 lat=2",
                       r, duty_out, period_out, is_static, smp - rs,
                       tbl[r].e_duty, tbl[r].e_per);
            end
          end
        end
      end
      chk($sformatf("tbl%0d_nvalid", r), nv, tbl[r].nper - 1);
    end

    // held low from reset: one static report, then silence
    do_reset(3);
    clr();
    run(1'b0, TO);
    chk("low_nv", g_nv, 1);
    chk("low_at", g_fsmp, TO);
    chk("low_duty", g_fd, 0);
    chk("low_static", g_fs, 1);
    chk("low_per", g_fp, 0);
    clr();
    run(1'b0, 10000);
    chk("low_repeat", g_nv, 0);

    // 600/1200 then stuck high, resume, then stuck low
    do_reset(3);
    for (int p = 0; p < 3; p++) begin
      run(1'b1, 600);
      run(1'b0, 600);
    end
    clr();
    rs = smp + 1;
    run(1'b1, 3000);
    chk("hi_nv", g_nv, 2);
    chk("hi_meas_duty", g_fd, 600);
    chk("hi_at", g_lsmp, rs + 2 + TO);
    chk("hi_duty", g_ld, PI - 1);
    chk("hi_static", g_ls, 1);
    chk("hi_per", g_lp, 0);
    clr();
    run(1'b0, 600);
    run(1'b1, 600);
    run(1'b0, 600);
    chk("resume_silent", g_nv, 0);
    rs2 = smp + 1;
    run(1'b1, 600);
    chk("resume_nv", g_nv, 1);
    chk("resume_at", g_fsmp, rs2 + 2);
    chk("resume_duty", g_fd, 600);
    chk("resume_per", g_fp, 1200);
    chk("resume_static", g_fs, 0);
    clr();
    run(1'b0, 2600);
    chk("lo_nv", g_nv, 1);
    chk("lo_at", g_fsmp, rs2 + 600 + 2 + TO);
    chk("lo_duty", g_fd, 0);
    chk("lo_static", g_fs, 1);

    // reset in the middle of a high phase
    do_reset(3);
    run(1'b1, 300);
    run(1'b0, 900);
    run(1'b1, 150);
    do_reset(3);
    clr();
    run(1'b1, 150);
    run(1'b0, 900);
    chk("mid_arm_silent", g_nv, 0);
    clr();
    run(1'b1, 300);
    run(1'b0, 900);
    chk("mid_part_nv", g_nv, 1);
    chk("mid_part_duty", g_fd, 150);
    chk("mid_part_per", g_fp, 1050);
    clr();
    rs = smp + 1;
    run(1'b1, 300);
    run(1'b0, 900);
    chk("mid_nv", g_nv, 1);
    chk("mid_at", g_fsmp, rs + 2);
    chk("mid_duty", g_fd, 300);
    chk("mid_per", g_fp, 1200);

    // random waveforms, glitch bursts and long holds
    do_reset(2);
    budget = 0;
    while (budget < 12000) begin
      m = int'($urandom_range(0, 2));
      case (m)
        0: begin
          h = int'($urandom_range(1, 2600));
          l = int'($urandom_range(1, 2600));
          run(1'b1, h);
          run(1'b0, l);
          budget += h + l;
        end
        1: begin
          for (int i = 0; i < 16; i++)
            step(1'($urandom_range(0, 1)));
          budget += 16;
        end
        default: begin
          h = int'($urandom_range(2300, 2600));
          run(pwm_in, h);
          budget += h;
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
